// File: rtl/idex_ctrl_stage.sv
// ID/EX control-word register: splits the decoded word into EX/M/WB fields and
// inserts load-use bubbles, honours flush and downstream hold, counts bubbles.
module idex_ctrl_stage #(
    parameter int EX_W          = 3,
    parameter int M_W           = 3,
    parameter int WB_W          = 2,
    parameter int BUBBLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [EX_W+M_W+WB_W-1:0]  ctrl_i,
    input  logic                      valid_i,
    input  logic                      hazard_i,
    input  logic                      flush_i,
    input  logic                      stall_i,
    output logic [EX_W-1:0]           EX_o,
    output logic [M_W-1:0]            M_o,
    output logic [WB_W-1:0]           WB_o,
    output logic                      valid_o,
    output logic                      stall_req_o,
    output logic [CNT_W-1:0]          bubble_cnt_o
);

    localparam int CTRL_W = EX_W + M_W + WB_W;
    localparam logic [3:0] REM_INIT = 4'(BUBBLE_CYCLES - 1);

    if (BUBBLE_CYCLES < 1 || BUBBLE_CYCLES > 15) begin : g_bad_bubble_cycles
        $fatal(1, "idex_ctrl_stage: BUBBLE_CYCLES must be in 1..15");
    end

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          rem_q, rem_d;
    logic [CTRL_W-1:0]   word_q, word_d;
    logic                vld_q, vld_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) return c;
        return c + CNT_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        word_d      = word_q;
        vld_d       = vld_q;
        cnt_d       = cnt_q;
        stall_req_o = ((state_q == RUN) && hazard_i) || ((state_q == BUBBLE) && (rem_q != 4'd0));

        if (flush_i) begin
            word_d  = '0;
            vld_d   = 1'b0;
            state_d = RUN;
            rem_d   = 4'd0;
        end else if (!stall_i) begin
            unique case (state_q)
                RUN: begin
                    if (hazard_i) begin
                        word_d  = '0;
                        vld_d   = 1'b0;
                        cnt_d   = sat_inc(cnt_q);
                        state_d = BUBBLE;
                        rem_d   = REM_INIT;
                    end else begin
                        word_d = valid_i ? ctrl_i : '0;
                        vld_d  = valid_i;
                    end
                end
                BUBBLE: begin
                    if (rem_q != 4'd0) begin
                        word_d = '0;
                        vld_d  = 1'b0;
                        cnt_d  = sat_inc(cnt_q);
                        rem_d  = rem_q - 4'd1;
                    end else begin
                        // Re-issued instruction: hazard_i is masked so it cannot re-trigger.
                        word_d  = valid_i ? ctrl_i : '0;
                        vld_d   = valid_i;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 4'd0;
                end
            endcase
        end
    end

    // ID -> EX register boundary
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            rem_q   <= 4'd0;
            word_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign EX_o         = word_q[CTRL_W-1 -: EX_W];
    assign M_o          = word_q[M_W+WB_W-1 -: M_W];
    assign WB_o         = word_q[WB_W-1:0];
    assign valid_o      = vld_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_idex_ctrl_stage.sv
// Scoreboard bench: directed rows push the expected cycle-visible outputs,
// a negedge monitor pops and compares them against the selected instance.
module tb_idex_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ctrl;
    logic       valid, hazard, flush, stall;

    logic [2:0] ex1, m1, ex3, m3;
    logic [1:0] wb1, wb3;
    logic       vld1, vld3, sreq1, sreq3;
    logic [15:0] cnt1;
    logic [1:0]  cnt3;

    always #5 clk = ~clk;

    idex_ctrl_stage u_dut1 (
        .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .valid_i(valid),
        .hazard_i(hazard), .flush_i(flush), .stall_i(stall),
        .EX_o(ex1), .M_o(m1), .WB_o(wb1), .valid_o(vld1),
        .stall_req_o(sreq1), .bubble_cnt_o(cnt1)
    );

    idex_ctrl_stage #(.BUBBLE_CYCLES(3), .CNT_W(2)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .valid_i(valid),
        .hazard_i(hazard), .flush_i(flush), .stall_i(stall),
        .EX_o(ex3), .M_o(m3), .WB_o(wb3), .valid_o(vld3),
        .stall_req_o(sreq3), .bubble_cnt_o(cnt3)
    );

    typedef struct {
        bit        chk;
        bit        sel;
        bit        rst;
        bit [7:0]  ctrl;
        bit        vld;
        bit        haz;
        bit        fl;
        bit        st;
        bit [7:0]  e_word;
        bit        e_vld;
        bit        e_sreq;
        bit [15:0] e_cnt;
    } vec_t;

    typedef struct {
        int        row;
        bit        sel;
        bit [7:0]  word;
        bit        vld;
        bit        sreq;
        bit [15:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input bit chk, input bit sel, input bit r, input bit [7:0] c,
                       input bit v, input bit h, input bit f, input bit s,
                       input bit [7:0] ew, input bit ev, input bit es, input bit [15:0] ec);
        vec_t x;
        x.chk = chk; x.sel = sel; x.rst = r; x.ctrl = c; x.vld = v; x.haz = h;
        x.fl = f; x.st = s; x.e_word = ew; x.e_vld = ev; x.e_sreq = es; x.e_cnt = ec;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int row, input bit [15:0] act, input bit [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s row%0d: got %h expected %h", name, row, act, req);
        end
    endtask

    // Monitor: every expectation describes the outputs visible during its cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.sel) begin
                check("word",  e.row, {8'h00, ex1, m1, wb1}, {8'h00, e.word});
                check("valid", e.row, {15'h0, vld1},  {15'h0, e.vld});
                check("sreq",  e.row, {15'h0, sreq1}, {15'h0, e.sreq});
                check("cnt",   e.row, cnt1, e.cnt);
            end else begin
                check("word",  e.row, {8'h00, ex3, m3, wb3}, {8'h00, e.word});
                check("valid", e.row, {15'h0, vld3},  {15'h0, e.vld});
                check("sreq",  e.row, {15'h0, sreq3}, {15'h0, e.sreq});
                check("cnt",   e.row, {14'h0, cnt3}, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single-bubble instance: load, one-cycle hazard, stall hold, flush under stall.
        //   chk sel rst ctrl   v h f s  word   v sreq cnt
        add(1, 0, 0, 8'hAE, 1, 0, 0, 0, 8'h00, 0, 0, 16'd0);
        add(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'hAE, 1, 0, 16'd0);
        add(1, 0, 0, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 1, 16'd0);
        add(1, 0, 0, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 0, 16'd1);
        add(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 1, 0, 16'd1);
        add(1, 0, 0, 8'h5A, 1, 0, 0, 0, 8'h00, 0, 0, 16'd1);
        add(1, 0, 0, 8'h33, 1, 1, 0, 1, 8'h5A, 1, 1, 16'd1);
        add(1, 0, 0, 8'h44, 1, 1, 0, 1, 8'h5A, 1, 1, 16'd1);
        add(1, 0, 0, 8'h55, 1, 1, 0, 1, 8'h5A, 1, 1, 16'd1);
        add(1, 0, 0, 8'h66, 1, 1, 0, 1, 8'h5A, 1, 1, 16'd1);
        add(1, 0, 0, 8'h77, 1, 1, 1, 1, 8'h5A, 1, 1, 16'd1);
        add(1, 0, 0, 8'hC3, 0, 0, 0, 0, 8'h00, 0, 0, 16'd1);
        add(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 16'd1);
        // Three-bubble instance with 2-bit counter.
        add(0, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 16'd0);
        add(1, 1, 0, 8'h81, 1, 1, 0, 0, 8'h00, 0, 1, 16'd0);
        add(1, 1, 0, 8'h81, 1, 1, 0, 0, 8'h00, 0, 1, 16'd1);
        add(1, 1, 0, 8'h81, 1, 1, 0, 0, 8'h00, 0, 1, 16'd2);
        add(1, 1, 0, 8'h81, 1, 1, 0, 0, 8'h00, 0, 0, 16'd3);
        add(1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h81, 1, 0, 16'd3);
        // Flush on the second bubble cycle aborts the sequence.
        add(1, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 16'd3);
        add(1, 1, 0, 8'h24, 1, 1, 0, 0, 8'h00, 0, 1, 16'd0);
        add(1, 1, 0, 8'h24, 1, 0, 0, 0, 8'h00, 0, 1, 16'd1);
        add(1, 1, 0, 8'h24, 1, 0, 1, 0, 8'h00, 0, 1, 16'd2);
        add(1, 1, 0, 8'h24, 1, 0, 0, 0, 8'h00, 0, 0, 16'd2);
        add(1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h24, 1, 0, 16'd2);
        // Counter saturation over five hazard pulses.
        add(1, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 16'd2);
        add(1, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 16'd0);
        add(1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 16'd1);
        add(1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 16'd2);
        add(1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 16'd3);
        for (int p = 0; p < 4; p++) begin
            add(1, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 16'd3);
            add(1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 16'd3);
            add(1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 16'd3);
            add(1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 16'd3);
        end
        // Reset in the middle of a bubble sequence.
        add(1, 1, 0, 8'h0F, 1, 1, 0, 0, 8'h00, 0, 1, 16'd3);
        add(1, 1, 0, 8'h0F, 1, 0, 0, 0, 8'h00, 0, 1, 16'd3);
        add(1, 1, 1, 8'h0F, 1, 0, 0, 0, 8'h00, 0, 1, 16'd3);
        add(1, 1, 0, 8'h0F, 1, 0, 0, 0, 8'h00, 0, 0, 16'd0);
        add(1, 1, 0, 8'h0F, 1, 1, 0, 0, 8'h0F, 1, 1, 16'd0);

        rst = 1'b1; ctrl = 8'h00; valid = 1'b0; hazard = 1'b0; flush = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            rst = vecs[i].rst; ctrl = vecs[i].ctrl; valid = vecs[i].vld;
            hazard = vecs[i].haz; flush = vecs[i].fl; stall = vecs[i].st;
            if (vecs[i].chk) begin
                e.row = i; e.sel = vecs[i].sel; e.word = vecs[i].e_word;
                e.vld = vecs[i].e_vld; e.sreq = vecs[i].e_sreq; e.cnt = vecs[i].e_cnt;
                exp_q.push_back(e);
            end
        end

        repeat (2) @(posedge clk);
        check("drain", -1, 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_ctrl_stage.md
Name: idex_ctrl_stage

Overview:
- Parametrised ID/EX control-word pipeline register with hazard bubble insertion, flush and downstream hold.
- Splits the decoded control word into EX, M and WB fields.
- On a load-use hazard, inserts BUBBLE_CYCLES consecutive all-zero control words and requests an upstream stall for the same span.
- Sits between the control unit / hazard detection unit and the EX stage. Also keeps a saturating count of bubbles inserted.

Parameters:
- EX_W, 3, width of EX control field (ctrl_i MSBs)
- M_W, 3, width of MEM control field (middle bits)
- WB_W, 2, width of WB control field (ctrl_i LSBs)
- BUBBLE_CYCLES, 1, bubbles inserted per hazard; legal range 1..15
- CNT_W, 16, width of bubble statistics counter

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- ctrl_i  input  EX_W+M_W+WB_W  control word; layout {EX, M, WB}, WB at bit 0
- valid_i  input  1  ctrl_i carries a real instruction
- hazard_i  input  1  load-use hazard detected for the instruction in ID
- flush_i  input  1  squash instruction entering EX (branch taken)
- stall_i  input  1  downstream hold; freeze stage
- EX_o  output  EX_W  registered EX control
- M_o  output  M_W  registered MEM control
- WB_o  output  WB_W  registered WB control
- valid_o  output  1  registered: EX stage holds a real instruction
- stall_req_o  output  1  combinational: hold PC and IF/ID this cycle
- bubble_cnt_o  output  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: EX_o, M_o, WB_o = 0; valid_o = 0; bubble_cnt_o = 0; state = RUN; rem = 0.
- Latency: 1 cycle from ctrl_i to outputs on a normal load.
- Edge priority, highest first: rst_i > flush_i > stall_i > bubble > normal load.

State machine:
- RUN, with hazard_i=1: load zero control word, valid_o=0, bubble_cnt_o+1.
  - If BUBBLE_CYCLES>1: go to BUBBLE with rem = BUBBLE_CYCLES-1.
  - Else: go to BUBBLE with rem = 0.
- RUN, with hazard_i=0: normal load. Outputs take the ctrl_i fields if valid_i=1, else all zero. valid_o = valid_i.
- BUBBLE, with rem != 0: load zeros, valid_o=0, bubble_cnt_o+1, rem-1. hazard_i is ignored.
- BUBBLE, with rem == 0: normal load of the re-issued instruction, return to RUN. hazard_i is masked this cycle.

stall_req_o:
- Equals (state==RUN & hazard_i) | (state==BUBBLE & rem!=0).
- Asserted for exactly BUBBLE_CYCLES cycles per hazard when stall_i and flush_i stay 0.

flush_i:
- Load zeros, valid_o=0, state=RUN, rem=0.
- bubble_cnt_o is not incremented.
- Overrides a simultaneous hazard_i or stall_i.
- A flush in the middle of a bubble sequence aborts the sequence.

stall_i (without flush_i):
- All output registers, state, rem and bubble_cnt_o hold.
- stall_req_o is still evaluated from the held state and hazard_i.

bubble_cnt_o:
- Saturates at 2^CNT_W-1; no wrap-around.

Reset mid-sequence:
- Returns to RUN immediately; stall_req_o is 0 in the cycle after rst_i falls unless hazard_i=1.

Field extraction:
- EX = ctrl_i[EX_W+M_W+WB_W-1 : M_W+WB_W]
- M = ctrl_i[M_W+WB_W-1 : WB_W]
- WB = ctrl_i[WB_W-1:0]

Width rules:
- No arithmetic on control fields.
- rem is 4 bits.
- BUBBLE_CYCLES outside 1..15 is a fatal elaboration-time error.

Test Plan:
- Defaults; ctrl_i=8'b101_011_10, valid_i=1 -> after 1 edge: EX_o=3'b101, M_o=3'b011, WB_o=2'b10, valid_o=1, stall_req_o=0.
- Defaults; hazard_i=1 for one cycle with ctrl_i=8'hFF -> stall_req_o=1 that cycle; next edge outputs all 0, valid_o=0, bubble_cnt_o=1; following edge loads 8'hFF even though hazard_i=1.
- BUBBLE_CYCLES=3; single hazard pulse -> stall_req_o high 3 consecutive cycles; 3 zero words; bubble_cnt_o=3; 4th edge loads ctrl_i.
- BUBBLE_CYCLES=3; flush_i=1 on second bubble cycle -> outputs 0, state RUN, stall_req_o=0 next cycle, bubble_cnt_o=2.
- Loaded word 8'h5A, then stall_i=1 for 4 cycles with changing ctrl_i and hazard_i=1 -> outputs stay 8'h5A fields, bubble_cnt_o unchanged; flush_i with stall_i -> zeros.
- CNT_W=2; 5 hazard pulses -> bubble_cnt_o=3, held. Assert rst_i during a BUBBLE_CYCLES=3 sequence -> all outputs 0, stall_req_o=0 next cycle.
